// File: rtl/dmem_if.sv
// Load/store bus between the core's MEM stage and the data-memory responder.
// The master drives the request fields; the slave returns data, ready and err.
interface dmem_if;
   logic        req;
   logic        mem_w;
   logic [31:0] Addr_in;
   logic [31:0] Data_wr;
   logic [3:0]  DMWType;
   logic [31:0] Data_rd;
   logic        MIO_ready;
   logic        err;

   modport master (
      output req, mem_w, Addr_in, Data_wr, DMWType,
      input  Data_rd, MIO_ready, err
   );

   modport slave (
      input  req, mem_w, Addr_in, Data_wr, DMWType,
      output Data_rd, MIO_ready, err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-lane store merge, aligned sub-word loads and optional wait states.
// Optional feature macro: DMEM_MMIO_EN adds an io_in/io_out window at Addr_in[31:16] == 16'hFFFF.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef DMEM_MMIO_EN
   input  logic [31:0] io_in,
   output logic [31:0] io_out,
`endif
   dmem_if.slave       bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            off;
   logic [4:0]            shamt;
   logic [7:0]            lane_wide;
   logic [3:0]            lane;
   logic [31:0]           wdata;
   logic [31:0]           size_mask;
   logic [31:0]           rd_word;
   logic [31:0]           rd_comb;
   logic                  mis;
   logic                  commit;
   logic                  array_we;
   logic                  rdy;
   logic [31:0]           rd_out;
   logic                  err_out;
`ifdef DMEM_MMIO_EN
   logic                  is_io;
   logic                  io_we;
`endif

   always_comb begin
      idx       = bus.Addr_in[ADDR_WIDTH+1:2];
      off       = bus.Addr_in[1:0];
      shamt     = {off, 3'b000};
      lane_wide = {4'b0000, bus.DMWType} << off;
      lane      = lane_wide[3:0];
      wdata     = bus.Data_wr << shamt;
      // loads are trimmed to the access size so the core only has to extend
      size_mask = {{8{bus.DMWType[3]}}, {8{bus.DMWType[2]}},
                   {8{bus.DMWType[1]}}, {8{bus.DMWType[0]}}};
      mis       = ((bus.DMWType == 4'b1111) && (off != 2'd0)) ||
                  ((bus.DMWType == 4'b0011) && (off == 2'd3));
`ifdef DMEM_MMIO_EN
      is_io     = (bus.Addr_in[31:16] == 16'hFFFF);
      rd_word   = is_io ? io_in : mem[idx];
      array_we  = commit & ~is_io;
      io_we     = commit & is_io;
`else
      rd_word   = mem[idx];
      array_we  = commit;
`endif
      rd_comb   = mis ? 32'd0 : ((rd_word >> shamt) & size_mask);
   end

   always_ff @(posedge clk) begin
      if (array_we) begin
         for (int b = 0; b < 4; b++) begin
            if (lane[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

`ifdef DMEM_MMIO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io_out <= '0;
      end else if (io_we) begin
         for (int b = 0; b < 4; b++) begin
            if (lane[b]) io_out[8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end
`endif

   generate
      if (WAIT_CYCLES == 0) begin : g_comb
         assign commit  = bus.req & bus.mem_w & ~mis;
         assign rdy     = bus.req;
         assign rd_out  = rd_comb;
         assign err_out = mis;
      end else begin : g_fsm
         // state  | meaning
         // S_IDLE | no access in flight; a request starts the wait count
         // S_WAIT | counting wait states; dropping req aborts without a write
         // S_RESP | MIO_ready high for one cycle, then back to S_IDLE
         localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
         typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

         state_t        state;
         logic [CW-1:0] cnt;
         logic          rdy_q;
         logic [31:0]   rd_q;
         logic          err_q;

         assign commit  = (state == S_WAIT) && bus.req && (cnt == '0) && bus.mem_w && !mis;
         assign rdy     = rdy_q;
         assign rd_out  = rd_q;
         assign err_out = err_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state <= S_IDLE;
               cnt   <= '0;
               rdy_q <= 1'b0;
               rd_q  <= '0;
               err_q <= 1'b0;
            end else begin
               rdy_q <= 1'b0;
               case (state)
                  S_IDLE: begin
                     if (bus.req) begin
                        state <= S_WAIT;
                        cnt   <= CW'(WAIT_CYCLES - 1);
                     end
                  end
                  S_WAIT: begin
                     if (!bus.req) begin
                        state <= S_IDLE;
                     end else if (cnt == '0) begin
                        state <= S_RESP;
                        rdy_q <= 1'b1;
                        rd_q  <= rd_comb;
                        err_q <= mis;
                     end else begin
                        cnt <= cnt - CW'(1);
                     end
                  end
                  S_RESP:  state <= S_IDLE;
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   endgenerate

   assign bus.MIO_ready = rdy;
   assign bus.Data_rd   = rd_out;
   assign bus.err       = err_out;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a zero-wait responder driven from a vector table and a
// three-wait-state responder exercised with hand-written multi-cycle sequences.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_if bus0 ();
   dmem_if bus3 ();

`ifdef DMEM_MMIO_EN
   logic [31:0] io_in;
   logic [31:0] io_out0;
   logic [31:0] io_out3;
`endif

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef DMEM_MMIO_EN
      .io_in (io_in),
      .io_out(io_out0),
`endif
      .bus   (bus0.slave)
   );

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef DMEM_MMIO_EN
      .io_in (io_in),
      .io_out(io_out3),
`endif
      .bus   (bus3.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        mem_w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mtype;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic w3_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] t, output logic [31:0] rd, output logic e,
                            output int lat);
      @(negedge clk);
      bus3.req     = 1'b1;
      bus3.mem_w   = w;
      bus3.Addr_in = a;
      bus3.Data_wr = d;
      bus3.DMWType = t;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus3.MIO_ready && lat < 20);
      rd = bus3.Data_rd;
      e  = bus3.err;
      bus3.req = 1'b0;
   endtask

   task automatic w0_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] t);
      @(negedge clk);
      bus0.req     = 1'b1;
      bus0.mem_w   = w;
      bus0.Addr_in = a;
      bus0.Data_wr = d;
      bus0.DMWType = t;
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      int          lat;
      int          highs;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 1'b0, 32'h0,         1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0012, 32'h0,         4'b0001, 1'b1, 32'h0000_0022, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0012, 32'h0,         4'b0011, 1'b1, 32'h0000_1122, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 1'b1, 32'h1122_3344, 1'b0};
      vecs[4]  = '{1'b1, 32'h0000_0013, 32'h0000_00AB, 4'b0001, 1'b1, 32'h0000_0011, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 1'b1, 32'hAB22_3344, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,         1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0003, 32'h0000_5555, 4'b0011, 1'b1, 32'h0,         1'b1};
      vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0002, 32'h1234_5678, 4'b1111, 1'b1, 32'h0,         1'b1};
      vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_0002, 32'h0000_CAFE, 4'b0011, 1'b1, 32'h0000_DEAD, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 1'b1, 32'hCAFE_BEEF, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_0001, 32'h0,         4'b0001, 1'b1, 32'h0000_00BE, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_1000, 32'h0,         4'b1111, 1'b1, 32'hCAFE_BEEF, 1'b0};
      vecs[15] = '{1'b1, 32'h0000_1010, 32'h0102_0304, 4'b1111, 1'b1, 32'hAB22_3344, 1'b0};
      vecs[16] = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 1'b1, 32'h0102_0304, 1'b0};
      vecs[17] = '{1'b0, 32'h0000_0011, 32'h0,         4'b1111, 1'b1, 32'h0,         1'b1};
      vecs[18] = '{1'b0, 32'h0000_0011, 32'h0,         4'b0011, 1'b1, 32'h0000_0203, 1'b0};
      vecs[19] = '{1'b0, 32'h0000_0013, 32'h0,         4'b0001, 1'b1, 32'h0000_0001, 1'b0};

      bus0.req = 1'b0; bus0.mem_w = 1'b0; bus0.Addr_in = '0; bus0.Data_wr = '0; bus0.DMWType = 4'b1111;
      bus3.req = 1'b0; bus3.mem_w = 1'b0; bus3.Addr_in = '0; bus3.Data_wr = '0; bus3.DMWType = 4'b1111;
`ifdef DMEM_MMIO_EN
      io_in = 32'hCAFE_BABE;
`endif

      repeat (3) @(negedge clk);
      check("rst_ready0", {31'd0, bus0.MIO_ready}, 32'd0);
      check("rst_ready3", {31'd0, bus3.MIO_ready}, 32'd0);
      check("rst_rd3",    bus3.Data_rd,            32'd0);
      check("rst_err3",   {31'd0, bus3.err},       32'd0);
`ifdef DMEM_MMIO_EN
      check("rst_io_out", io_out0, 32'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         w0_access(vecs[i].mem_w, vecs[i].addr, vecs[i].wdata, vecs[i].mtype);
         check($sformatf("v%0d_ready", i), {31'd0, bus0.MIO_ready}, 32'd1);
         check($sformatf("v%0d_err", i),   {31'd0, bus0.err},       {31'd0, vecs[i].exp_err});
         if (vecs[i].chk_rd) check($sformatf("v%0d_rd", i), bus0.Data_rd, vecs[i].exp_rd);
      end
      @(negedge clk);
      bus0.req = 1'b0;
      #1;
      check("w0_idle_ready", {31'd0, bus0.MIO_ready}, 32'd0);

`ifdef DMEM_MMIO_EN
      w0_access(1'b1, 32'h0000_0004, 32'h0BAD_F00D, 4'b1111);
      w0_access(1'b1, 32'hFFFF_0004, 32'h5A5A_0001, 4'b1111);
      w0_access(1'b0, 32'h0000_0004, 32'h0, 4'b1111);
      check("mmio_io_out",    io_out0,      32'h5A5A_0001);
      check("mmio_array_rd",  bus0.Data_rd, 32'h0BAD_F00D);
      w0_access(1'b0, 32'hFFFF_0001, 32'h0, 4'b0001);
      check("mmio_lbu",       bus0.Data_rd, 32'h0000_00BA);
      w0_access(1'b1, 32'hFFFF_0002, 32'h0000_1234, 4'b1111);
      check("mmio_mis_err",   {31'd0, bus0.err}, 32'd1);
      w0_access(1'b0, 32'h0000_0000, 32'h0, 4'b1111);
      check("mmio_mis_nowr",  io_out0,      32'h5A5A_0001);
`else
      w0_access(1'b1, 32'hFFFF_0004, 32'h7777_7777, 4'b1111);
      w0_access(1'b0, 32'h0000_0004, 32'h0, 4'b1111);
      check("alias_hi_rd", bus0.Data_rd, 32'h7777_7777);
`endif
      @(negedge clk);
      bus0.req = 1'b0;

      w3_access(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'b1111, rd, e, lat);
      check("w3_sw_lat", lat, 32'd4);
      check("w3_sw_err", {31'd0, e}, 32'd0);
      @(negedge clk);
      check("w3_ready_one_cycle", {31'd0, bus3.MIO_ready}, 32'd0);

      w3_access(1'b0, 32'h0000_0020, 32'h0, 4'b1111, rd, e, lat);
      check("w3_lw_lat", lat, 32'd4);
      check("w3_lw_rd",  rd,  32'hA5A5_0F0F);
      @(negedge clk);
      check("w3_rd_held",   bus3.Data_rd, 32'hA5A5_0F0F);
      check("w3_ready_low", {31'd0, bus3.MIO_ready}, 32'd0);

      // store withdrawn after two cycles must never land
      @(negedge clk);
      bus3.req = 1'b1; bus3.mem_w = 1'b1; bus3.Addr_in = 32'h20;
      bus3.Data_wr = 32'hFFFF_FFFF; bus3.DMWType = 4'b1111;
      @(negedge clk);
      bus3.req = 1'b0;
      highs = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus3.MIO_ready) highs++;
      end
      check("w3_abort_no_ready", highs, 32'd0);
      w3_access(1'b0, 32'h0000_0020, 32'h0, 4'b1111, rd, e, lat);
      check("w3_abort_lat", lat, 32'd4);
      check("w3_abort_nowr", rd, 32'hA5A5_0F0F);

      @(negedge clk);
      bus3.req = 1'b1; bus3.mem_w = 1'b1; bus3.Addr_in = 32'h20;
      bus3.Data_wr = 32'h0000_0000; bus3.DMWType = 4'b1111;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("w3_rst_ready", {31'd0, bus3.MIO_ready}, 32'd0);
      check("w3_rst_rd",    bus3.Data_rd,            32'd0);
      check("w3_rst_err",   {31'd0, bus3.err},       32'd0);
      bus3.req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      w3_access(1'b0, 32'h0000_1020, 32'h0, 4'b1111, rd, e, lat);
      check("w3_rst_nowr_alias", rd, 32'hA5A5_0F0F);

      w3_access(1'b1, 32'h0000_0023, 32'h0000_9999, 4'b0011, rd, e, lat);
      check("w3_mis_lat", lat, 32'd4);
      check("w3_mis_err", {31'd0, e}, 32'd1);
      check("w3_mis_rd",  rd, 32'd0);
      w3_access(1'b0, 32'h0000_0022, 32'h0, 4'b0011, rd, e, lat);
      check("w3_mis_nowr", rd, 32'h0000_A5A5);
      check("w3_lhu_err",  {31'd0, e}, 32'd0);

      // back-to-back: req held through RESP restarts one cycle later
      @(negedge clk);
      bus3.req = 1'b1; bus3.mem_w = 1'b0; bus3.Addr_in = 32'h20; bus3.DMWType = 4'b0001;
      lat = 0; highs = 0;
      while (highs < 2 && lat < 30) begin
         @(negedge clk);
         lat++;
         if (bus3.MIO_ready) highs++;
      end
      bus3.req = 1'b0;
      check("w3_b2b_cycles", lat, 32'd9);
      check("w3_b2b_rd", bus3.Data_rd, 32'h0000_000F);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
